// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter: FSM states, requester count
// and the latched operation record.
package alu_arb_pkg;

    localparam int NREQ   = 2;
    localparam int ALU_W  = 32;
    localparam int ALU_CW = 4;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic [ALU_W-1:0]  d1;
        logic [ALU_W-1:0]  d2;
        logic [ALU_CW-1:0] control;
    } alu_req_t;

    function automatic logic [NREQ-1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response handshake bundle between the two requesters and the arbiter.
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int CW    = 4
) ();
    import alu_arb_pkg::*;

    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0][WIDTH-1:0] req_d1;
    logic [NREQ-1:0][WIDTH-1:0] req_d2;
    logic [NREQ-1:0][CW-1:0]    req_control;
    logic [NREQ-1:0]            rsp_valid;
    logic [NREQ-1:0]            rsp_ready;
    logic [WIDTH-1:0]           rsp_result;

    // master = requester side, slave = arbiter side
    modport master (
        output req_valid, req_d1, req_d2, req_control, rsp_ready,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_d1, req_d2, req_control, rsp_ready,
        output req_ready, rsp_valid, rsp_result
    );

endinterface

// File: rtl/alu_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to the
// requester that did not win last time.
module rr_pick2
    import alu_arb_pkg::*;
(
    input  logic [NREQ-1:0] req_valid,
    input  logic            last_grant,
    output logic [NREQ-1:0] grant,
    output logic            grant_idx
);

    always_comb begin
        grant_idx = 1'b0;
        if (req_valid == 2'b11) begin
            grant_idx = ~last_grant;
        end else if (req_valid[1]) begin
            grant_idx = 1'b1;
        end
        grant = (req_valid != '0) ? onehot2(grant_idx) : '0;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Non-pipelined arbiter sharing one combinational ALU between two requesters:
// grant in IDLE, drive the ALU for one EXEC cycle, hold the result in RESP.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int CW    = ALU_CW
) (
    input  logic             clk,
    input  logic             rst,
    alu_arbiter_if.slave     bus,
    output logic [WIDTH-1:0] alu_d1,
    output logic [WIDTH-1:0] alu_d2,
    output logic [CW-1:0]    alu_control,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);

    arb_state_t      state;
    logic            last_grant;
    logic            owner;
    alu_req_t        op;
    logic [WIDTH-1:0] result_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic [NREQ-1:0] grant;
    logic            grant_idx;

    rr_pick2 u_pick (
        .req_valid (bus.req_valid),
        .last_grant(last_grant),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // req_ready is the only combinational output; everything else comes from registers
    assign bus.req_ready  = (state == IDLE) ? grant : '0;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = result_q;
    assign alu_d1         = op.d1;
    assign alu_d2         = op.d2;
    assign alu_control    = op.control;

    // op is nonzero only during EXEC, so it doubles as the ALU input register
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            op          <= '0;
            result_q    <= '0;
            rsp_valid_q <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid != '0) begin
                        op <= '{d1:      bus.req_d1[grant_idx],
                                d2:      bus.req_d2[grant_idx],
                                control: bus.req_control[grant_idx]};
                        owner      <= grant_idx;
                        last_grant <= grant_idx;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    result_q    <= alu_result;
                    op          <= '0;
                    rsp_valid_q <= onehot2(owner);
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready[owner]) begin
                        rsp_valid_q <= '0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
